// File: rtl/aes_sbox_sched.sv
// aes_sbox_sched
// Round-robin scheduler sharing one pipelined masked AES S-box between NREQ
// requesters. Each issue captures the winner's shared byte into the S-box
// input register and pushes a tag (valid, requester ID) into a pipeline whose
// depth matches the S-box latency. The returning shares are registered and
// routed back with the originating ID. Shares are never recombined here.
//
// Request/grant handshake: a requester raises ReqxSI[r] and keeps it high with
// stable data until it sees GntxSO[r]=1. Data is captured at the end of that
// cycle. While BusyxSO[r]=1 the requester is not granted again. Responses have
// no backpressure: RspValidxSO is a single-cycle pulse that must be accepted.
//
// Ports:
//   ClkxCI, RstxBI       clock (rising edge), asynchronous active-low reset
//   EnablexSI            allows new issue
//   ReqxSI, ReqDataxDI   per-requester request and shared input byte
//   GntxSO               one-hot grant (combinational, issue cycle)
//   RndValidxSI          fresh randomness available
//   RndConsumexSO        randomness word consumed on this edge
//   SboxInxDO            registered S-box input shares
//   SboxOutxDI           S-box output shares
//   RspValidxSO/IdxDO/DataxDO  response pulse, requester ID, masked result
//   BusyxSO              per-requester operation outstanding
//   IdlexSO              FSM idle and no operation in flight
//   DbgStatexDO          FSM state (0 IDLE, 1 RUN, 2 DRAIN)
module aes_sbox_sched #(
  parameter int SHARES   = 2,
  parameter int NREQ     = 4,
  parameter int SBOX_LAT = 4,
  parameter int IDW      = 2
) (
  input  logic                     ClkxCI,
  input  logic                     RstxBI,
  input  logic                     EnablexSI,
  input  logic [NREQ-1:0]          ReqxSI,
  input  logic [NREQ*8*SHARES-1:0] ReqDataxDI,
  output logic [NREQ-1:0]          GntxSO,
  input  logic                     RndValidxSI,
  output logic                     RndConsumexSO,
  output logic [8*SHARES-1:0]      SboxInxDO,
  input  logic [8*SHARES-1:0]      SboxOutxDI,
  output logic                     RspValidxSO,
  output logic [IDW-1:0]           RspIdxDO,
  output logic [8*SHARES-1:0]      RspDataxDO,
  output logic [NREQ-1:0]          BusyxSO,
  output logic                     IdlexSO,
  output logic [1:0]               DbgStatexDO
);

  localparam int DW   = 8 * SHARES;
  localparam int NTAG = SBOX_LAT + 1;
  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [DW-1:0]   sbox_in_q, sbox_in_d;
  logic [NREQ-1:0] busy_q, busy_d;
  logic [NTAG-1:0] tag_vld_q, tag_vld_d;
  logic [IDW-1:0]  tag_id_q [NTAG];
  logic [IDW-1:0]  tag_id_d [NTAG];
  logic            rsp_vld_q, rsp_vld_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;

  logic [NREQ-1:0] eligible;
  logic            found;
  logic [IDW-1:0]  winner;
  logic [IDW:0]    idx;
  logic            issue;
  logic            in_flight;

  // Round-robin search: first eligible requester at or after the pointer.
  always_comb begin
    eligible = ReqxSI & ~busy_q;
    found    = 1'b0;
    winner   = '0;
    idx      = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, ptr_q} + (IDW+1)'(i);
      if (idx >= NREQ_W) idx = idx - NREQ_W;
      if (!found && eligible[idx[IDW-1:0]]) begin
        found  = 1'b1;
        winner = idx[IDW-1:0];
      end
    end
  end

  assign in_flight = |tag_vld_q;
  assign issue     = (state_q == ST_RUN) && EnablexSI && RndValidxSI && found;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (EnablexSI) state_d = ST_RUN;
      ST_RUN:   if (!EnablexSI) state_d = in_flight ? ST_DRAIN : ST_IDLE;
      ST_DRAIN: begin
        if (EnablexSI)       state_d = ST_RUN;
        else if (!in_flight) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ptr_d      = ptr_q;
    sbox_in_d  = sbox_in_q;
    busy_d     = busy_q;
    tag_vld_d  = {tag_vld_q[NTAG-2:0], issue};
    tag_id_d[0] = winner;
    for (int k = 1; k < NTAG; k++) tag_id_d[k] = tag_id_q[k-1];
    // The last tag stage lines up with valid S-box output shares.
    rsp_vld_d  = tag_vld_q[NTAG-1];
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    if (tag_vld_q[NTAG-1]) begin
      rsp_id_d   = tag_id_q[NTAG-1];
      rsp_data_d = SboxOutxDI;
      busy_d[tag_id_q[NTAG-1]] = 1'b0;
    end
    // Without an issue the S-box input is held so no share toggles occur.
    if (issue) begin
      ptr_d          = (winner == LAST_ID) ? '0 : winner + 1'b1;
      sbox_in_d      = ReqDataxDI[winner*DW +: DW];
      busy_d[winner] = 1'b1;
    end
  end

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      sbox_in_q  <= '0;
      busy_q     <= '0;
      tag_vld_q  <= '0;
      for (int k = 0; k < NTAG; k++) tag_id_q[k] <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sbox_in_q  <= sbox_in_d;
      busy_q     <= busy_d;
      tag_vld_q  <= tag_vld_d;
      for (int k = 0; k < NTAG; k++) tag_id_q[k] <= tag_id_d[k];
      rsp_vld_q  <= rsp_vld_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign GntxSO        = issue ? (NREQ'(1) << winner) : '0;
  assign RndConsumexSO = issue;
  assign SboxInxDO     = sbox_in_q;
  assign RspValidxSO   = rsp_vld_q;
  assign RspIdxDO      = rsp_id_q;
  assign RspDataxDO    = rsp_data_q;
  assign BusyxSO       = busy_q;
  assign IdlexSO       = (state_q == ST_IDLE) && !in_flight;
  assign DbgStatexDO   = state_q;

endmodule

// File: tb/tb_aes_sbox_sched.sv
// Testbench for aes_sbox_sched: a behavioural S-box environment, a cycle model
// derived from the scheduling rules, directed vector tables and random traffic.
module tb_aes_sbox_sched;
  localparam int SHARES   = 2;
  localparam int NREQ     = 4;
  localparam int SBOX_LAT = 4;
  localparam int IDW      = 2;
  localparam int DW       = 8 * SHARES;

  logic                 clk;
  logic                 RstxBI;
  logic                 EnablexSI;
  logic [NREQ-1:0]      ReqxSI;
  logic [NREQ*DW-1:0]   ReqDataxDI;
  logic [NREQ-1:0]      GntxSO;
  logic                 RndValidxSI;
  logic                 RndConsumexSO;
  logic [DW-1:0]        SboxInxDO;
  logic [DW-1:0]        SboxOutxDI;
  logic                 RspValidxSO;
  logic [IDW-1:0]       RspIdxDO;
  logic [DW-1:0]        RspDataxDO;
  logic [NREQ-1:0]      BusyxSO;
  logic                 IdlexSO;
  logic [1:0]           DbgStatexDO;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  aes_sbox_sched #(.SHARES(SHARES), .NREQ(NREQ), .SBOX_LAT(SBOX_LAT), .IDW(IDW)) dut (
    .ClkxCI(clk), .RstxBI(RstxBI), .EnablexSI(EnablexSI), .ReqxSI(ReqxSI),
    .ReqDataxDI(ReqDataxDI), .GntxSO(GntxSO), .RndValidxSI(RndValidxSI),
    .RndConsumexSO(RndConsumexSO), .SboxInxDO(SboxInxDO), .SboxOutxDI(SboxOutxDI),
    .RspValidxSO(RspValidxSO), .RspIdxDO(RspIdxDO), .RspDataxDO(RspDataxDO),
    .BusyxSO(BusyxSO), .IdlexSO(IdlexSO), .DbgStatexDO(DbgStatexDO)
  );

  // ---------------- AES S-box reference (GF(2^8) inverse + affine) ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_f(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (gf_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Pipelined masked S-box environment: SBOX_LAT cycles, fresh output mask.
  logic [7:0] pipe_x [SBOX_LAT];
  logic [7:0] pipe_m [SBOX_LAT];
  always @(posedge clk) begin
    pipe_x[0] <= SboxInxDO[7:0] ^ SboxInxDO[15:8];
    pipe_m[0] <= 8'($urandom);
    for (int i = 1; i < SBOX_LAT; i++) begin
      pipe_x[i] <= pipe_x[i-1];
      pipe_m[i] <= pipe_m[i-1];
    end
  end
  assign SboxOutxDI = {pipe_m[SBOX_LAT-1], sbox_f(pipe_x[SBOX_LAT-1]) ^ pipe_m[SBOX_LAT-1]};

  // ---------------- scoreboard / model state ----------------
  typedef struct packed {
    logic [31:0]    due;
    logic [IDW-1:0] id;
    logic [7:0]     val;
  } exp_t;
  exp_t exp_q[$];

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         ptr_m = 0;
  int         fsm_m = 0;          // 0 IDLE, 1 RUN, 2 DRAIN
  logic [DW-1:0] sbox_in_m = '0;
  logic [7:0] last_rsp_m = 8'h00;
  logic [7:0] plain [NREQ];
  logic [7:0] mask  [NREQ];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_bus();
    for (int r = 0; r < NREQ; r++)
      ReqDataxDI[r*DW +: DW] = {mask[r], plain[r] ^ mask[r]};
  endtask

  // Checks every observable output of the current cycle against the model,
  // then advances the model across the next clock edge.
  task automatic check_cycle();
    logic [NREQ-1:0] busy_e;
    logic [NREQ-1:0] gnt_e;
    bit infl, found, iss;
    int rsp_idx, win, r;
    busy_e = '0; infl = 0; rsp_idx = -1; found = 0; win = 0;
    foreach (exp_q[i]) begin
      if (int'(exp_q[i].due) > cyc) begin
        busy_e[exp_q[i].id] = 1'b1;
        infl = 1;
      end
      if (int'(exp_q[i].due) == cyc) rsp_idx = i;
    end
    chk("busy", 32'(BusyxSO), 32'(busy_e));
    chk("rsp_valid", 32'(RspValidxSO), 32'(rsp_idx >= 0));
    if (rsp_idx >= 0) begin
      chk("rsp_id", 32'(RspIdxDO), 32'(exp_q[rsp_idx].id));
      last_rsp_m = exp_q[rsp_idx].val;
    end
    chk("rsp_data", 32'(RspDataxDO[7:0] ^ RspDataxDO[15:8]), 32'(last_rsp_m));
    chk("sbox_in", 32'(SboxInxDO), 32'(sbox_in_m));
    chk("idle", 32'(IdlexSO), 32'(fsm_m == 0 && !infl));
    chk("state", 32'(DbgStatexDO), 32'(fsm_m));
    for (int i = 0; i < NREQ; i++) begin
      r = (ptr_m + i) % NREQ;
      if (!found && ReqxSI[r] && !busy_e[r]) begin
        found = 1;
        win = r;
      end
    end
    iss = (fsm_m == 1) && EnablexSI && RndValidxSI && found;
    gnt_e = iss ? NREQ'(1 << win) : '0;
    chk("gnt", 32'(GntxSO), 32'(gnt_e));
    chk("rnd_consume", 32'(RndConsumexSO), 32'(iss));
    if (rsp_idx >= 0) exp_q.delete(rsp_idx);
    if (iss) begin
      exp_q.push_back('{due: 32'(cyc + SBOX_LAT + 2), id: IDW'(win), val: sbox_f(plain[win])});
      ptr_m = (win + 1) % NREQ;
      sbox_in_m = {mask[win], plain[win] ^ mask[win]};
    end
    case (fsm_m)
      0: if (EnablexSI) fsm_m = 1;
      1: if (!EnablexSI) fsm_m = infl ? 2 : 0;
      default: if (EnablexSI) fsm_m = 1; else if (!infl) fsm_m = 0;
    endcase
    cyc++;
  endtask

  task automatic step(input logic en, input logic [NREQ-1:0] req, input logic rnd, input bit rand_data);
    @(negedge clk);
    if (rand_data)
      for (int r = 0; r < NREQ; r++) begin
        plain[r] = 8'($urandom);
        mask[r]  = 8'($urandom);
      end
    EnablexSI = en;
    ReqxSI = req;
    RndValidxSI = rnd;
    drive_bus();
    #1;
    check_cycle();
  endtask

  // Asserts reset immediately, checks the reset values, clears the model.
  task automatic do_reset();
    RstxBI = 1'b0;
    EnablexSI = 1'b0;
    ReqxSI = '0;
    RndValidxSI = 1'b0;
    #1;
    chk("rst_gnt", 32'(GntxSO), 0);
    chk("rst_consume", 32'(RndConsumexSO), 0);
    chk("rst_sbox_in", 32'(SboxInxDO), 0);
    chk("rst_rsp_valid", 32'(RspValidxSO), 0);
    chk("rst_rsp_id", 32'(RspIdxDO), 0);
    chk("rst_rsp_data", 32'(RspDataxDO), 0);
    chk("rst_busy", 32'(BusyxSO), 0);
    chk("rst_idle", 32'(IdlexSO), 1);
    exp_q.delete();
    ptr_m = 0; fsm_m = 0; sbox_in_m = '0; last_rsp_m = 8'h00; cyc = 0;
    @(negedge clk);
    #2 RstxBI = 1'b1;
  endtask

  // Reset, then one cycle with enable so the FSM sits in RUN at cycle 0.
  task automatic fresh_run();
    do_reset();
    step(1'b1, '0, 1'b0, 0);
    cyc = 0;
  endtask

  // ---------------- directed vector tables ----------------
  typedef struct {
    logic           en;
    logic [NREQ-1:0] req;
    logic           rnd;
    logic [NREQ-1:0] gnt;
    logic           rsp_v;
    logic [IDW-1:0] rsp_id;
    logic [7:0]     rsp_byte;
  } vec_t;
  vec_t tab_q[$];

  task automatic run_table(input string name);
    for (int r = 0; r < NREQ; r++) begin
      plain[r] = 8'(r);
      mask[r]  = 8'($urandom);
    end
    foreach (tab_q[i]) begin
      step(tab_q[i].en, tab_q[i].req, tab_q[i].rnd, 0);
      chk({name, "_gnt"}, 32'(GntxSO), 32'(tab_q[i].gnt));
      chk({name, "_rsp_v"}, 32'(RspValidxSO), 32'(tab_q[i].rsp_v));
      if (tab_q[i].rsp_v) begin
        chk({name, "_rsp_id"}, 32'(RspIdxDO), 32'(tab_q[i].rsp_id));
        chk({name, "_rsp_byte"}, 32'(RspDataxDO[7:0] ^ RspDataxDO[15:8]), 32'(tab_q[i].rsp_byte));
      end
    end
    tab_q.delete();
  endtask

  logic [NREQ-1:0] rq;
  int rsp_seen;

  initial begin
    RstxBI = 1'b1; EnablexSI = 1'b0; ReqxSI = '0; RndValidxSI = 1'b0; ReqDataxDI = '0;
    for (int r = 0; r < NREQ; r++) begin plain[r] = 8'h00; mask[r] = 8'h00; end
    #2;

    // Single requester, known shares of 0x53.
    fresh_run();
    plain[0] = 8'h53; mask[0] = 8'hA5;
    step(1'b1, 4'b0001, 1'b1, 0);
    chk("t1_gnt", 32'(GntxSO), 32'h1);
    for (int c = 1; c <= 6; c++) step(1'b1, 4'b0000, 1'b1, 0);
    chk("t1_rsp_valid", 32'(RspValidxSO), 1);
    chk("t1_rsp_id", 32'(RspIdxDO), 0);
    chk("t1_rsp_byte", 32'(RspDataxDO[7:0] ^ RspDataxDO[15:8]), 32'hED);

    // Four requesters at once, round-robin order, pointer wraps to 0.
    fresh_run();
    tab_q.push_back('{1'b1, 4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0, 8'h00});
    tab_q.push_back('{1'b1, 4'b1110, 1'b1, 4'b0010, 1'b0, 2'd0, 8'h00});
    tab_q.push_back('{1'b1, 4'b1100, 1'b1, 4'b0100, 1'b0, 2'd0, 8'h00});
    tab_q.push_back('{1'b1, 4'b1000, 1'b1, 4'b1000, 1'b0, 2'd0, 8'h00});
    tab_q.push_back('{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00});
    tab_q.push_back('{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00});
    tab_q.push_back('{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 8'h63});
    tab_q.push_back('{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1, 8'h7C});
    tab_q.push_back('{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 8'h77});
    tab_q.push_back('{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3, 8'h7B});
    tab_q.push_back('{1'b1, 4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0, 8'h00});
    run_table("rr4");

    // Randomness stall with requesters 1 and 3 held.
    fresh_run();
    tab_q.push_back('{1'b1, 4'b1010, 1'b1, 4'b0010, 1'b0, 2'd0, 8'h00});
    tab_q.push_back('{1'b1, 4'b1010, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00});
    tab_q.push_back('{1'b1, 4'b1010, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00});
    tab_q.push_back('{1'b1, 4'b1010, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00});
    tab_q.push_back('{1'b1, 4'b1010, 1'b1, 4'b1000, 1'b0, 2'd0, 8'h00});
    tab_q.push_back('{1'b1, 4'b1010, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00});
    tab_q.push_back('{1'b1, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h7C});
    run_table("stall");

    // Requester 2 held high: regrant only once its response arrives.
    fresh_run();
    for (int c = 0; c <= 12; c++) begin
      step(1'b1, 4'b0100, 1'b1, 1);
      chk("hold_gnt", 32'(GntxSO), (c % 6 == 0) ? 32'h4 : 32'h0);
      if (c >= 1 && c <= 5) chk("hold_busy2", 32'(BusyxSO[2]), 1);
    end

    // Drain: three ops then enable low.
    fresh_run();
    step(1'b1, 4'b0111, 1'b1, 1);
    step(1'b1, 4'b0110, 1'b1, 1);
    step(1'b1, 4'b0100, 1'b1, 1);
    for (int c = 3; c <= 10; c++) begin
      step(1'b0, 4'b1000, 1'b1, 1);
      if (c == 3) chk("drain_gnt", 32'(GntxSO), 0);
      if (c == 4) chk("drain_state", 32'(DbgStatexDO), 2);
      if (c >= 6 && c <= 8) chk("drain_rsp", 32'(RspValidxSO), 1);
      if (c == 8) chk("drain_idle_early", 32'(IdlexSO), 0);
      if (c == 9) chk("drain_idle", 32'(IdlexSO), 1);
    end

    // Reset with two ops in flight: nothing may come back.
    fresh_run();
    step(1'b1, 4'b0011, 1'b1, 1);
    step(1'b1, 4'b0010, 1'b1, 1);
    step(1'b1, 4'b0000, 1'b1, 1);
    @(posedge clk);
    #2;
    do_reset();
    rsp_seen = 0;
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 4'b0000, 1'b1, 1);
      if (RspValidxSO) rsp_seen++;
    end
    chk("rst_no_rsp", 32'(rsp_seen), 0);
    chk("rst_busy_after", 32'(BusyxSO), 0);

    // Random traffic against the model.
    fresh_run();
    for (int c = 0; c < 600; c++) begin
      rq = NREQ'($urandom);
      step($urandom_range(0, 19) != 0, rq, $urandom_range(0, 3) != 0, 1);
    end
    for (int c = 0; c < 12; c++) step(1'b0, '0, 1'b1, 1);
    chk("final_idle", 32'(IdlexSO), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
